// File: rtl/traffic_pkg.sv
// Shared phase codes for the intersection sequencer and the display path.
// Codes 5..7 are never produced; the sequencer recovers from them via CLEAR.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_WALK   = 3'd0,
        PH_HURRY  = 3'd1,
        PH_CLEAR  = 3'd2,
        PH_YELLOW = 3'd3,
        PH_GREEN  = 3'd4
    } phase_e;

    localparam int PHASE_W = 3;

    // Fixed ring WALK -> HURRY -> GREEN -> YELLOW -> CLEAR -> WALK.
    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_WALK:   return PH_HURRY;
            PH_HURRY:  return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_CLEAR;
            PH_CLEAR:  return PH_WALK;
            default:   return PH_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running 0..TICKS_PER_SEC-1 wrap counter producing the one-second tick.
// hold freezes the count so releasing it resumes without an extra tick.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] tcnt_q;
    logic          at_last;

    assign at_last = (tcnt_q == LAST);
    assign tick    = at_last & ~hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if (!hold) begin
            tcnt_q <= at_last ? '0 : tcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Intersection phase FSM: per-phase seconds countdown, pedestrian request
// latch that clamps the remaining car green, and illegal-code recovery.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int WALK_SEC      = 5,
    parameter int HURRY_SEC     = 3,
    parameter int GREEN_SEC     = 9,
    parameter int YELLOW_SEC    = 2,
    parameter int CLEAR_SEC     = 1,
    parameter int PED_GREEN_SEC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       hold,
    output logic [2:0] cur_phase,
    output logic [3:0] seven_num,
    output logic       ped_pending,
    output logic       phase_done
);

    localparam logic [3:0] CLEAR_DUR = 4'(CLEAR_SEC);
    localparam logic [3:0] PED_CAP   = 4'(PED_GREEN_SEC);

    logic       tick;
    phase_e     phase_q, phase_d, nxt;
    logic [3:0] sec_q, sec_d, eff;
    logic       ped_q, ped_d;
    logic       done_q, done_d;
    logic       legal, expire;

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clk (clk),
        .rst (rst),
        .hold(hold),
        .tick(tick)
    );

    function automatic logic [3:0] dur_of(input phase_e ph);
        case (ph)
            PH_WALK:   return 4'(WALK_SEC);
            PH_HURRY:  return 4'(HURRY_SEC);
            PH_GREEN:  return 4'(GREEN_SEC);
            PH_YELLOW: return 4'(YELLOW_SEC);
            default:   return CLEAR_DUR;
        endcase
    endfunction

    assign legal  = (phase_q <= PH_GREEN);
    assign nxt    = next_phase(phase_q);
    // A pending pedestrian caps the remaining green, even while hold is set.
    assign eff    = (phase_q == PH_GREEN && ped_q && sec_q > PED_CAP) ? PED_CAP : sec_q;
    assign expire = legal && tick && (eff == 4'd1);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the branches below can infer a latch.
        phase_d = phase_q;
        sec_d   = eff;
        done_d  = 1'b0;
        ped_d   = ped_q;

        if (!legal) begin
            phase_d = PH_CLEAR;
            sec_d   = CLEAR_DUR;
            done_d  = 1'b1;
        end else if (expire) begin
            phase_d = nxt;
            sec_d   = dur_of(nxt);
            done_d  = 1'b1;
        end else if (tick) begin
            sec_d   = eff - 4'd1;
        end

        // Entry into WALK clears the latch and wins over a same-cycle request.
        if (expire && nxt == PH_WALK) begin
            ped_d = 1'b0;
        end else if (ped_req && phase_q != PH_WALK && phase_q != PH_HURRY) begin
            ped_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_CLEAR;
            sec_q   <= CLEAR_DUR;
            ped_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sec_q   <= sec_d;
            ped_q   <= ped_d;
            done_q  <= done_d;
        end
    end

    assign cur_phase   = phase_q;
    assign seven_num   = sec_q;
    assign ped_pending = ped_q;
    assign phase_done  = done_q;

endmodule
